// File: rtl/adc_pkg.sv
// Shared widths, default decimation ratio and FSM encoding for the ADC sample path.
package adc_pkg;
  localparam int ADC_DATA_W   = 12;
  localparam int DECIM_LOG2_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;
endpackage

// File: rtl/adc_peak_tracker.sv
// Running min/max over one decimation block; the trackers restart at the end of
// every block and whenever acquisition is aborted.
module adc_peak_tracker
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              fpga_clk,
  input  logic              button_rst,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic              sample_last,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] blk_min,
  output logic [DATA_W-1:0] blk_max
);

  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;

  // Folds in the current sample so the last sample of a block is included.
  always_comb begin
    blk_min = (sample_data < run_min) ? sample_data : run_min;
    blk_max = (sample_data > run_max) ? sample_data : run_max;
  end

  always_ff @(posedge fpga_clk) begin
    if (!button_rst || clear || (sample_valid && sample_last)) begin
      run_min <= '1;
      run_max <= '0;
    end else if (sample_valid) begin
      run_min <= blk_min;
      run_max <= blk_max;
    end
  end

endmodule

// File: rtl/adc_decimator.sv
// Boxcar decimator: averages blocks of 2^LOG2_N ADC samples onto a valid/ready output.
// Define ADC_DECIM_PEAK_EN to add per-block out_min/out_max outputs.
//
// state | meaning
// IDLE  | acquisition disabled; acc/cnt held at zero, in_valid ignored
// ACC   | accumulating samples into the current block
module adc_decimator
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int LOG2_N = DECIM_LOG2_N
) (
  input  logic              fpga_clk,
  input  logic              button_rst,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              overrun
`ifdef ADC_DECIM_PEAK_EN
  ,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max
`endif
);

  localparam int ACC_W = DATA_W + LOG2_N;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [LOG2_N-1:0] cnt;
  logic [ACC_W-1:0]  sum;
  logic              accept;
  logic              block_done;
  logic              load;

  // Samples count only when already in ACC and still enabled this cycle.
  assign accept     = (state == ACC) && enable && in_valid;
  assign block_done = accept && (cnt == '1);
  assign sum        = acc + ACC_W'(in_data);
  assign load       = block_done && (!out_valid || out_ready);

`ifdef ADC_DECIM_PEAK_EN
  logic [DATA_W-1:0] blk_min;
  logic [DATA_W-1:0] blk_max;

  adc_peak_tracker #(.DATA_W(DATA_W)) u_peak (
    .fpga_clk     (fpga_clk),
    .button_rst   (button_rst),
    .clear        ((state != ACC) || !enable),
    .sample_valid (accept),
    .sample_last  (block_done),
    .sample_data  (in_data),
    .blk_min      (blk_min),
    .blk_max      (blk_max)
  );

  always_ff @(posedge fpga_clk) begin
    if (!button_rst) begin
      out_min <= '1;
      out_max <= '0;
    end else if (load) begin
      out_min <= blk_min;
      out_max <= blk_max;
    end
  end
`endif

  always_ff @(posedge fpga_clk) begin
    if (!button_rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          acc <= '0;
          cnt <= '0;
          if (enable) state <= ACC;
        end
        ACC: begin
          if (!enable) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (in_valid) begin
            if (cnt == '1) begin
              acc <= '0;
              cnt <= '0;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Output register is independent of state so a pending result survives IDLE.
      if (load) begin
        out_data  <= DATA_W'(sum >> LOG2_N);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (block_done && out_valid && !out_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_decimator.sv
// Self-checking bench for adc_decimator at LOG2_N = 2 (blocks of four samples).
module tb_adc_decimator;

  localparam int DW = 12;

  logic          fpga_clk;
  logic          button_rst;
  logic          enable;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          overrun;
`ifdef ADC_DECIM_PEAK_EN
  logic [DW-1:0] out_min;
  logic [DW-1:0] out_max;
`endif

  adc_decimator #(.DATA_W(DW), .LOG2_N(2)) dut (
    .fpga_clk   (fpga_clk),
    .button_rst (button_rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .overrun    (overrun)
`ifdef ADC_DECIM_PEAK_EN
    ,
    .out_min    (out_min),
    .out_max    (out_max)
`endif
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
  } exp_t;

  typedef struct {
    logic [DW-1:0] s [4];
    logic [DW-1:0] avg;
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
  } vec_t;

  exp_t exp_q[$];
  vec_t vec [5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] s);
    in_valid = 1'b1;
    in_data  = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [DW-1:0] mn, input logic [DW-1:0] mx);
    exp_t e;
    e.data = d; e.mn = mn; e.mx = mx;
    exp_q.push_back(e);
  endtask

  task automatic set_vec(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d,
                         input logic [DW-1:0] avg, input logic [DW-1:0] mn, input logic [DW-1:0] mx);
    vec[i].s[0] = a; vec[i].s[1] = b; vec[i].s[2] = c; vec[i].s[3] = d;
    vec[i].avg = avg; vec[i].mn = mn; vec[i].mx = mx;
  endtask

  // Every handshake transfer is matched against the next queued expectation.
  always @(negedge fpga_clk) begin
    if (button_rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer actual data %0d required no transfer", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_data", out_data, e.data);
`ifdef ADC_DECIM_PEAK_EN
        chk("xfer_min", out_min, e.mn);
        chk("xfer_max", out_max, e.mx);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    button_rst = 1'b0;
    enable     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;

    set_vec(0, 10,   20,   30,   41,   25,   10,   41);
    set_vec(1, 4095, 4095, 4095, 4095, 4095, 4095, 4095);
    set_vec(2, 0,    0,    0,    3,    0,    0,    3);
    set_vec(3, 1,    2,    3,    6,    3,    1,    6);
    set_vec(4, 100,  200,  7,    4000, 1076, 7,    4000);

    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overrun", overrun, 0);
`ifdef ADC_DECIM_PEAK_EN
    chk("rst_min", out_min, 12'hFFF);
    chk("rst_max", out_max, 0);
`endif

    button_rst = 1'b1;
    enable     = 1'b1;
    out_ready  = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      push(vec[i].avg, vec[i].mn, vec[i].mx);
      for (int k = 0; k < 4; k++) send(vec[i].s[k]);
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, vec[i].avg);
      step();
      chk("vec_valid_drop", out_valid, 0);
      step();
    end

    // Two blocks with the consumer stalled: first result held, second dropped.
    out_ready = 1'b0;
    send4(5, 5, 5, 5);
    chk("ovr_first_valid", out_valid, 1);
    chk("ovr_first_data", out_data, 5);
    chk("ovr_first_flag", overrun, 0);
    send4(9, 9, 9, 9);
    chk("ovr_hold_data", out_data, 5);
    chk("ovr_flag", overrun, 1);
    step();
    chk("ovr_hold_valid", out_valid, 1);
    chk("ovr_hold_data2", out_data, 5);
    push(5, 5, 5);
    out_ready = 1'b1;
    step();
    chk("ovr_drained", out_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // Reset with a pending result and three samples into the next block.
    out_ready = 1'b0;
    send4(2, 2, 2, 2);
    send(7); send(7); send(7);
    chk("pre_rst_valid", out_valid, 1);
    button_rst = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_overrun", overrun, 0);
`ifdef ADC_DECIM_PEAK_EN
    chk("mid_rst_min", out_min, 12'hFFF);
    chk("mid_rst_max", out_max, 0);
`endif
    button_rst = 1'b1;
    step();
    out_ready = 1'b1;
    push(13, 12, 16);
    send4(12, 12, 12, 16);
    chk("post_rst_data", out_data, 13);
    step();

    // Consumer accepts the pending result in the cycle the next block completes.
    out_ready = 1'b0;
    send4(8, 8, 8, 8);
    chk("b2b_pending", out_valid, 1);
    push(8, 8, 8);
    push(1, 1, 1);
    send(1); send(1); send(1);
    out_ready = 1'b1;
    send(1);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, 1);
    chk("b2b_overrun", overrun, 0);
    step();
    chk("b2b_drop", out_valid, 0);

    // Enable drop mid-block discards the partial block; disabled samples are ignored.
    send(100); send(100);
    in_valid = 1'b1;
    in_data  = 100;
    enable   = 1'b0;
    step();
    in_valid = 1'b0;
    send(50); send(50); send(50);
    chk("dis_valid", out_valid, 0);
    enable = 1'b1;
    step();
    push(8, 8, 8);
    send4(8, 8, 8, 8);
    chk("reen_data", out_data, 8);
    chk("reen_overrun", overrun, 0);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
